range_loader: RTL

- Streaming writer that fills the solver's range memory.
- Accepts the puzzle's ASCII range list one byte per handshake, e.g. "11-22,95-115\n".
- Parses each range into two unsigned 64-bit integers and writes one 128-bit entry per range through a synchronous write port.
- Entry layout is {end[127:64], start[63:0]}; the solver array reads the same layout.
- Reports entry count, completion and parse errors.

---
 rtl/range_loader_pkg.sv | 23 ++
 rtl/range_loader_dec_accum.sv | 35 +++
 rtl/range_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/range_loader_pkg.sv
// Shared types and constants for the range-list loader: parser states,
// ASCII codes and entry/value widths.
package loader_pkg;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_END   = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    localparam int ENTRY_W = 128;
    localparam int VAL_W   = 64;

endpackage

// File: rtl/range_loader_dec_accum.sv
// 64-bit decimal accumulator: acc <= acc*10 + digit, with overflow flag
// computed on the 68-bit intermediate.
module dec_accum
    import loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             digit_en,
    input  logic [3:0]       digit,
    output logic [VAL_W-1:0] value,
    output logic [VAL_W-1:0] next_value,
    output logic             overflow
);

    logic [VAL_W+3:0] acc_wide;
    logic [VAL_W+3:0] prod;

    assign acc_wide   = {4'b0000, value};
    assign prod       = (acc_wide << 3) + (acc_wide << 1) + {{VAL_W{1'b0}}, digit};
    assign next_value = prod[VAL_W-1:0];
    assign overflow   = |prod[VAL_W+3:VAL_W];

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every register samples pre-edge values.
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (digit_en && !overflow) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/range_loader.sv
// Streaming ASCII range-list parser that writes {end, start} entries into
// the solver's range memory, one entry per parsed range.
module range_loader
    import loader_pkg::*;
#(
    parameter int RANGE_COUNT = 38,
    parameter int ADDR_W      = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [ENTRY_W-1:0] wr_data,
    output logic [ADDR_W:0]    range_count,
    output logic               done,
    output logic               error
);

    localparam logic [ADDR_W:0] CAP = (ADDR_W + 1)'(RANGE_COUNT);
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t           state, state_n;
    logic [VAL_W-1:0] start_q, start_n;
    logic             have, have_n;

    logic             acc_clr, acc_dig, acc_ovf;
    logic [VAL_W-1:0] acc_value, acc_next, end_val;

    logic fire, is_digit, is_term, is_blank;
    logic emit_req, emit, err;

    assign fire     = in_valid && in_ready;
    assign is_digit = (in_data >= CH_0) && (in_data <= CH_9);
    assign is_term  = (in_data == CH_COMMA) || (in_data == CH_LF);
    assign is_blank = (in_data == CH_SP) || (in_data == CH_CR);
    // An in_last on a digit closes the range with the digit already folded in.
    assign end_val  = is_digit ? acc_next : acc_value;

    dec_accum u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (acc_clr),
        .digit_en   (acc_dig),
        .digit      (in_data[3:0]),
        .value      (acc_value),
        .next_value (acc_next),
        .overflow   (acc_ovf)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_n  = state;
        start_n  = start_q;
        have_n   = have;
        acc_clr  = 1'b0;
        acc_dig  = 1'b0;
        emit_req = 1'b0;
        emit     = 1'b0;
        err      = 1'b0;

        if (fire) begin
            if (is_digit) begin
                acc_dig = 1'b1;
                if (acc_ovf) err = 1'b1;
                else         have_n = 1'b1;
            end else if (in_data == CH_DASH) begin
                if (state == S_START && have) begin
                    start_n = acc_value;
                    acc_clr = 1'b1;
                    have_n  = 1'b0;
                    state_n = S_END;
                end else begin
                    err = 1'b1;
                end
            end else if (is_term) begin
                if (state == S_END) begin
                    if (have) emit_req = 1'b1;
                    else      err = 1'b1;
                end else if (have) begin
                    err = 1'b1;
                end
            end else if (!is_blank) begin
                err = 1'b1;
            end

            if (in_last && !err && !emit_req && state_n == S_END) begin
                if (have_n) emit_req = 1'b1;
                else        err = 1'b1;
            end

            if (emit_req && !err) begin
                if (start_n > end_val || range_count == CAP) begin
                    err = 1'b1;
                end else begin
                    emit    = 1'b1;
                    acc_clr = 1'b1;
                    have_n  = 1'b0;
                    state_n = S_START;
                end
            end

            if (in_last && !err) state_n = S_DONE;
            if (err)             state_n = S_ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_START;
            start_q     <= '0;
            have        <= 1'b0;
            in_ready    <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            range_count <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state    <= state_n;
            start_q  <= start_n;
            have     <= have_n;
            in_ready <= (state_n == S_START) || (state_n == S_END);
            wr_en    <= emit;
            if (emit) begin
                wr_addr     <= range_count[ADDR_W-1:0];
                wr_data     <= {end_val, start_q};
                range_count <= range_count + ONE;
            end
            done  <= (state_n == S_DONE);
            error <= (state_n == S_ERR);
        end
    end

endmodule
